// File: rtl/mio_bus_bridge.sv
// Data-side bus bridge: SCPU memory port to data RAM, LED, cycle counter, UART TX FIFO and status.
// Optional build macro MIO_CYCLE_COUNTER_EN adds the free-running CYCLE register at 0xF000_0004.
module mio_bus_bridge #(
    parameter int RAM_WAIT = 1,
    parameter int TX_DEPTH = 8,
    parameter int LED_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    output logic             ram_we,
    output logic [9:0]       ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    output logic [LED_W-1:0] led_out,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [29:0] LED_WORD  = 30'h3C00_0000;
    localparam logic [29:0] CYC_WORD  = 30'h3C00_0001;
    localparam logic [29:0] TX_WORD   = 30'h3C00_0002;
    localparam logic [29:0] STAT_WORD = 30'h3C00_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM_ACC,
        S_RAM_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [31:0] reg_rdata;
    logic [31:0] cycle_val;
    logic        bus_err;
    logic        tx_ovf;

    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tx_empty;
    logic             tx_full;

    // Byte-lane bits only select within a word; the whole map is word-granular.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

    logic [29:0] word;
    logic        hit_ram, hit_led, hit_cyc, hit_tx, hit_stat, hit_err;

    assign word     = cpu_addr[31:2];
    assign hit_ram  = (cpu_addr[31:12] == 20'h0_0000);
    assign hit_led  = (word == LED_WORD);
    assign hit_cyc  = (word == CYC_WORD);
    assign hit_tx   = (word == TX_WORD);
    assign hit_stat = (word == STAT_WORD);
    assign hit_err  = !(hit_ram || hit_led || hit_cyc || hit_tx || hit_stat);

    // Peripheral side effects all happen on the single edge that leaves IDLE.
    logic accept, tx_push, tx_pop, do_push, stat_rd;

    assign accept  = (state == S_IDLE) && cpu_req;
    assign tx_push = accept && hit_tx && cpu_we;
    assign tx_pop  = tx_valid && tx_ready;
    assign do_push = tx_push && (!tx_full || tx_pop);
    assign stat_rd = accept && hit_stat && !cpu_we;

    assign ram_addr  = cpu_addr[11:2];
    assign ram_wdata = cpu_wdata;

    assign tx_empty = (count == '0);
    assign tx_full  = (count == CNT_W'(TX_DEPTH));
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : fifo_mem[rd_ptr];

`ifdef MIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (!rst) cycle_q <= '0;
        else      cycle_q <= cycle_q + 32'd1;
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        // NOTE: default first so no path through the mux leaves reg_rdata unassigned (no latch).
        reg_rdata = '0;
        if (hit_led)       reg_rdata = 32'(led_out);
        else if (hit_cyc)  reg_rdata = cycle_val;
        else if (hit_stat) reg_rdata = {28'b0, bus_err, tx_ovf, tx_full, tx_empty};
        else if (hit_err)  reg_rdata = 32'hDEAD_BEEF;
    end

    always_ff @(posedge clk) begin
        // NOTE: storage array carries no reset; pointers and count alone define what is valid.
        if (rst && do_push) fifo_mem[wr_ptr] <= cpu_wdata[7:0];
    end

    // NOTE: every sequential assignment uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_ovf  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !tx_pop)      count <= count + 1'b1;
            else if (!do_push && tx_pop) count <= count - 1'b1;

            // Set events take priority over the read-to-clear of STATUS.
            if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
            else if (stat_rd)                  tx_ovf <= 1'b0;

            if (accept && hit_err) bus_err <= 1'b1;
            else if (stat_rd)      bus_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            ram_we    <= 1'b0;
            led_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (hit_ram) begin
                            state  <= S_RAM_ACC;
                            ram_we <= cpu_we;
                        end else begin
                            state     <= S_DONE;
                            cpu_ready <= 1'b1;
                            cpu_rdata <= reg_rdata;
                            if (cpu_we && hit_led) led_out <= cpu_wdata[LED_W-1:0];
                        end
                    end
                end
                S_RAM_ACC: begin
                    ram_we <= 1'b0;
                    if (RAM_WAIT == 0) begin
                        state     <= S_DONE;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= ram_rdata;
                    end else begin
                        state    <= S_RAM_WAIT;
                        wait_cnt <= 3'(RAM_WAIT - 1);
                    end
                end
                S_RAM_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state     <= S_DONE;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= ram_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cpu_ready <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    cpu_ready <= 1'b0;
                    ram_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
